// File: rtl/n64_reply_scheduler.sv
// N64 controller reply sequencer: selects the reply payload, waits out bus turnaround, then bit-serially drives the open-drain line.
// Optional N64_PAK_STATUS_EN adds pak_present, which reports controller-pak presence in INFO/RESET byte 2.
module n64_reply_scheduler #(
  parameter int US_TICKS      = 50,
  parameter int TURNAROUND_US = 2
) (
  input  logic        sample_clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd,
  input  logic [31:0] buttons,
`ifdef N64_PAK_STATUS_EN
  input  logic        pak_present,
`endif
  output logic        data_oe,
  output logic        rx_enable,
  output logic        busy,
  output logic        done,
  output logic        cmd_error
);

  localparam int TW = $clog2(4 * US_TICKS);
  localparam logic [TW-1:0] T1 = TW'(US_TICKS - 1);
  localparam logic [TW-1:0] T2 = TW'(2 * US_TICKS - 1);
  localparam logic [TW-1:0] T3 = TW'(3 * US_TICKS - 1);

  typedef enum logic [2:0] {IDLE, TURN, BIT_LOW, BIT_HIGH, STOP, DONE} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tick;
  logic [4:0]    bit_idx;
  logic [4:0]    last_idx;
  logic [31:0]   payload;
  logic          phase_end;
  logic          accept;
  logic          bad_cmd;
  logic [7:0]    info_b2;

`ifdef N64_PAK_STATUS_EN
  assign info_b2 = pak_present ? 8'h01 : 8'h02;
`else
  assign info_b2 = 8'h02;
`endif

  always_comb begin
    state_nxt = state;
    phase_end = 1'b0;
    accept    = 1'b0;
    bad_cmd   = 1'b0;
    case (state)
      TURN:     phase_end = (tick == T1) && (bit_idx == 5'(TURNAROUND_US - 1));
      BIT_LOW:  phase_end = (tick == (payload[31] ? T1 : T3));
      BIT_HIGH: phase_end = (tick == (payload[31] ? T3 : T1));
      STOP:     phase_end = (tick == T2);
      default:  phase_end = 1'b0;
    endcase
    case (state)
      IDLE: begin
        // The done register still being high means the previous reply is closing out.
        if (cmd_valid && !done) begin
          if (cmd == 8'h00 || cmd == 8'hFF || cmd == 8'h01) begin
            accept    = 1'b1;
            state_nxt = TURN;
          end else begin
            bad_cmd = 1'b1;
          end
        end
      end
      TURN:     if (phase_end) state_nxt = BIT_LOW;
      BIT_LOW:  if (phase_end) state_nxt = BIT_HIGH;
      BIT_HIGH: if (phase_end) state_nxt = (bit_idx == last_idx) ? STOP : BIT_LOW;
      STOP:     if (phase_end) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sample_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // During TURN bit_idx counts elapsed microseconds, so tick never exceeds one bit slot.
  always_ff @(posedge sample_clk or posedge reset) begin
    if (reset) begin
      tick     <= '0;
      bit_idx  <= '0;
      last_idx <= '0;
      payload  <= '0;
    end else begin
      case (state)
        IDLE: begin
          tick    <= '0;
          bit_idx <= '0;
          if (accept) begin
            if (cmd == 8'h01) begin
              payload  <= buttons;
              last_idx <= 5'd31;
            end else begin
              payload  <= {8'h05, 8'h00, info_b2, 8'h00};
              last_idx <= 5'd23;
            end
          end
        end
        TURN: begin
          if (tick == T1) begin
            tick    <= '0;
            bit_idx <= phase_end ? 5'd0 : bit_idx + 5'd1;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        BIT_HIGH: begin
          if (phase_end) begin
            tick    <= '0;
            payload <= {payload[30:0], 1'b0};
            if (bit_idx != last_idx) bit_idx <= bit_idx + 5'd1;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        BIT_LOW, STOP: tick <= phase_end ? '0 : tick + 1'b1;
        default: tick <= '0;
      endcase
    end
  end

  always_ff @(posedge sample_clk or posedge reset) begin
    if (reset) begin
      data_oe   <= 1'b0;
      rx_enable <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_error <= 1'b0;
    end else begin
      data_oe   <= (state == BIT_LOW) || (state == STOP);
      busy      <= (state == TURN) || (state == BIT_LOW) || (state == BIT_HIGH) || (state == STOP);
      rx_enable <= !((state == TURN) || (state == BIT_LOW) || (state == BIT_HIGH) || (state == STOP));
      done      <= (state == DONE);
      cmd_error <= bad_cmd;
    end
  end

endmodule

// File: tb/tb_n64_reply_scheduler.sv
// Scoreboard bench for n64_reply_scheduler (US_TICKS=4, TURNAROUND_US=2): the monitor decodes the data_oe waveform into bits.
module tb_n64_reply_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [7:0]  cmd;
  logic [31:0] buttons;
  logic        pak_present;
  logic        data_oe, rx_enable, busy, done, cmd_error;

  always #5 clk = ~clk;

  n64_reply_scheduler #(.US_TICKS(4), .TURNAROUND_US(2)) dut (
    .sample_clk(clk),
    .reset(rst),
    .cmd_valid(cmd_valid),
    .cmd(cmd),
    .buttons(buttons),
`ifdef N64_PAK_STATUS_EN
    .pak_present(pak_present),
`endif
    .data_oe(data_oe),
    .rx_enable(rx_enable),
    .busy(busy),
    .done(done),
    .cmd_error(cmd_error)
  );

`ifdef N64_PAK_STATUS_EN
  localparam logic [31:0] INFO_WORD = 32'h0005_0001;
`else
  localparam logic [31:0] INFO_WORD = 32'h0005_0002;
`endif

  typedef struct packed {
    logic        is_err;
    logic [5:0]  nbits;
    logic [31:0] word;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: decodes low-pulse widths (4 = '1', 12 = '0', 8 = stop) and scores each done/cmd_error.
  int          cyc = 0;
  int          low_cnt, nbits, first_rise, last_fall;
  logic        prev_oe, stop_seen, rx_bad;
  logic [31:0] word;
  exp_t        e;

  task automatic clear_decode();
    prev_oe = 1'b0; low_cnt = 0; nbits = 0; word = '0;
    stop_seen = 1'b0; rx_bad = 1'b0; first_rise = -1; last_fall = 0;
  endtask

  initial clear_decode();

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      clear_decode();
    end else begin
      if (data_oe && !prev_oe) begin
        low_cnt = 1;
        if (first_rise < 0) first_rise = cyc;
      end else if (data_oe) begin
        low_cnt++;
      end else if (prev_oe) begin
        if (low_cnt == 4) begin word = {word[30:0], 1'b1}; nbits++; end
        else if (low_cnt == 12) begin word = {word[30:0], 1'b0}; nbits++; end
        else if (low_cnt == 8) begin stop_seen = 1'b1; last_fall = cyc; end
        else begin
          total++; bad++;
          $display("FAIL low_width: got %0d cycles expected 4, 8 or 12", low_cnt);
        end
      end
      prev_oe = data_oe;
      if ((busy || data_oe) && rx_enable) rx_bad = 1'b1;
      if (done) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got done pulse expected none at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("reply_kind", 32'(e.is_err), 32'd0);
          check("reply_nbits", nbits, 32'(e.nbits));
          check("reply_word", word, e.word);
          check("stop_bit", 32'(stop_seen), 32'd1);
          check("oe_window", last_fall - first_rise, 32'(e.nbits) * 16 + 8);
          check("rx_gated", 32'(rx_bad), 32'd0);
        end
        clear_decode();
      end
      if (cmd_error) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_err: got cmd_error expected none at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("err_kind", 32'(e.is_err), 32'd1);
        end
      end
    end
  end

  task automatic send(input logic [7:0] c);
    @(negedge clk);
    cmd = c;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 3000) begin
      @(posedge clk); #1; k++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done expected done within 3000 cycles");
    end
  endtask

  task automatic measure_latency();
    int k = 0;
    while (!data_oe && k < 100) begin
      @(posedge clk); #1; k++;
    end
    check("first_rise_latency", k, 9);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd = 8'h00; buttons = '0;
`ifdef N64_PAK_STATUS_EN
    pak_present = 1'b1;
`else
    pak_present = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_oe", 32'(data_oe), 0);
    check("rst_rx_enable", 32'(rx_enable), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cmd_error", 32'(cmd_error), 0);
    @(negedge clk) rst = 1'b0;

    // INFO reply
    sb.push_back('{1'b0, 6'd24, INFO_WORD});
    send(8'h00);
    measure_latency();
    wait_done();
    repeat (5) @(posedge clk);

    // STATUS reply; the buttons change mid-reply must not reach the line
    buttons = 32'h8001_00FF;
    sb.push_back('{1'b0, 6'd32, 32'h8001_00FF});
    send(8'h01);
    repeat (100) @(negedge clk);
    buttons = 32'hDEAD_BEEF;
    wait_done();
    // cmd_valid presented while done is high is dropped
    cmd = 8'h00;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("done_cycle_ignored_busy", 32'(busy), 0);
    check("done_cycle_ignored_oe", 32'(data_oe), 0);

    // Unsupported command
    sb.push_back('{1'b1, 6'd0, 32'd0});
    send(8'h02);
    check("err_pulse", 32'(cmd_error), 1);
    check("err_busy", 32'(busy), 0);
    @(posedge clk); #1;
    check("err_pulse_end", 32'(cmd_error), 0);
    repeat (15) @(posedge clk);
    #1;
    check("err_no_reply_oe", 32'(data_oe), 0);
    check("err_no_reply_busy", 32'(busy), 0);

    // RESET command with a second strobe arriving mid-reply
    sb.push_back('{1'b0, 6'd24, INFO_WORD});
    send(8'hFF);
    repeat (60) @(negedge clk);
    cmd = 8'hFF;
    cmd_valid = 1'b1;
    @(negedge clk) cmd_valid = 1'b0;
    wait_done();
    repeat (600) @(posedge clk);
    #1;
    check("single_reply_busy", 32'(busy), 0);

    // Reset in the middle of a STATUS reply while the line is pulled low
    buttons = 32'hFFFF_FFFF;
    send(8'h01);
    measure_latency();
    #2 rst = 1'b1;
    #1;
    check("midrst_data_oe", 32'(data_oe), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_rx_enable", 32'(rx_enable), 1);
    @(negedge clk) rst = 1'b0;
    repeat (700) @(posedge clk);
    #1;
    check("midrst_idle_oe", 32'(data_oe), 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
